// File: rtl/pipe_ctrl_pkg.sv
// =============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int CNT_W          = 16;
    localparam int STALL_W        = CNT_W;
    localparam int WDOG_W         = CNT_W;
    localparam int WDOG_LIMIT_DEF = 255;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_wr;
        logic if_id_wr;
        logic id_ex_wr;
        logic ex_mem_wr;
        logic mem_wb_wr;
        logic pc_flush;
        logic if_flush;
        logic id_flush;
        logic ex_flush;
    } ctrl_t;

    localparam ctrl_t c_ctrl_pass = '{
        pc_wr: 1'b1, if_id_wr: 1'b1, id_ex_wr: 1'b1, ex_mem_wr: 1'b1, mem_wb_wr: 1'b1,
        pc_flush: 1'b0, if_flush: 1'b0, id_flush: 1'b0, ex_flush: 1'b0
    };

    localparam ctrl_t c_ctrl_hold = '{
        pc_wr: 1'b0, if_id_wr: 1'b0, id_ex_wr: 1'b0, ex_mem_wr: 1'b0, mem_wb_wr: 1'b0,
        pc_flush: 1'b0, if_flush: 1'b0, id_flush: 1'b0, ex_flush: 1'b0
    };

    localparam ctrl_t c_ctrl_commit = '{
        pc_wr: 1'b1, if_id_wr: 1'b1, id_ex_wr: 1'b1, ex_mem_wr: 1'b1, mem_wb_wr: 1'b1,
        pc_flush: 1'b1, if_flush: 1'b1, id_flush: 1'b1, ex_flush: 1'b1
    };

    localparam ctrl_t c_ctrl_reset = '{
        pc_wr: 1'b0, if_id_wr: 1'b0, id_ex_wr: 1'b0, ex_mem_wr: 1'b0, mem_wb_wr: 1'b0,
        pc_flush: 1'b1, if_flush: 1'b1, id_flush: 1'b1, ex_flush: 1'b1
    };

    function automatic cnt_t sat_inc(input cnt_t v);
        return (&v) ? v : v + cnt_t'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// =============================================================================
// Module      : pipe_ctrl_if
// Description : Hazard inputs and stage-control outputs of the pipeline controller.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic               exc_commit;
    logic               eret_commit;
    logic               data_req;
    logic               data_data_ok;
    logic               div_busy;
    logic               load_use;
    logic               inst_addr_ok;
    logic               inst_data_ok;
    logic               inst_req;
    logic               pc_wr;
    logic               if_id_wr;
    logic               id_ex_wr;
    logic               ex_mem_wr;
    logic               mem_wb_wr;
    logic               PC_Flush;
    logic               IF_Flush;
    logic               ID_Flush;
    logic               EX_Flush;
    logic [STALL_W-1:0] stall_cnt;
    logic               wdog_to;

    // Controller side
    modport master (
        input  exc_commit, eret_commit, data_req, data_data_ok,
        input  div_busy, load_use, inst_addr_ok, inst_data_ok,
        output inst_req, pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
        output PC_Flush, IF_Flush, ID_Flush, EX_Flush, stall_cnt, wdog_to
    );

    // Pipeline side
    modport slave (
        output exc_commit, eret_commit, data_req, data_data_ok,
        output div_busy, load_use, inst_addr_ok, inst_data_ok,
        input  inst_req, pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
        input  PC_Flush, IF_Flush, ID_Flush, EX_Flush, stall_cnt, wdog_to
    );

endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_perf.sv
// =============================================================================
// Module      : pipe_ctrl_perf
// Description : Saturating stall counter and sticky data-wait watchdog.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pipe_ctrl_perf
    import pipe_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_stall,
    input  wire logic               i_wait,
    output logic      [STALL_W-1:0] o_stall_cnt,
    output logic                    o_wdog_to
);

    localparam cnt_t c_wdog_lim = cnt_t'(WDOG_LIMIT);

    cnt_t r_stall_cnt;
    cnt_t r_wdog_cnt;
    cnt_t w_wdog_inc;
    logic r_wdog_to;

    assign w_wdog_inc = sat_inc(r_wdog_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_wdog_cnt  <= '0;
            r_wdog_to   <= 1'b0;
        end else begin
            if (i_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            // The wait count only spans an unbroken run of data-wait cycles.
            if (i_wait) begin
                r_wdog_cnt <= w_wdog_inc;
                if (w_wdog_inc >= c_wdog_lim) begin
                    r_wdog_to <= 1'b1;
                end
            end else begin
                r_wdog_cnt <= '0;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_wdog_to   = r_wdog_to;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// =============================================================================
// Module      : pipe_ctrl
// Description : Five-stage pipeline stall/flush controller with fetch drain FSM.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  wire logic    clk,
    input  wire logic    rst,
    pipe_ctrl_if.master  bus
);

    state_e r_state;
    state_e w_state_nxt;
    logic   r_inst_pending;
    logic   w_inst_pending_nxt;
    logic   w_commit;
    logic   w_dwait;
    logic   w_fwait;
    logic   w_inst_req;
    logic   w_wait_cycle;
    ctrl_t  w_ctrl;

    assign w_commit   = bus.exc_commit | bus.eret_commit;
    assign w_dwait    = bus.data_req & ~bus.data_data_ok;
    assign w_fwait    = r_inst_pending & ~bus.inst_data_ok;
    assign w_inst_req = ~rst & (r_state == ST_RUN) & ~r_inst_pending & ~w_dwait;

    // A new acceptance outranks a same-cycle return of the previous fetch.
    always_comb begin
        w_inst_pending_nxt = r_inst_pending;
        if (w_inst_req && bus.inst_addr_ok) begin
            w_inst_pending_nxt = 1'b1;
        end else if (bus.inst_data_ok) begin
            w_inst_pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_inst_pending <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_inst_pending <= w_inst_pending_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_commit) begin
            w_state_nxt = w_fwait ? ST_DRAIN : ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:   if (w_dwait)           w_state_nxt = ST_DWAIT;
                ST_DWAIT: if (!w_dwait)          w_state_nxt = ST_RUN;
                ST_DRAIN: if (bus.inst_data_ok)  w_state_nxt = ST_RUN;
                default:                         w_state_nxt = ST_RUN;
            endcase
        end
    end

    // DRAIN discards the wrong-path fetch still in flight after a commit.
    always_comb begin
        w_ctrl = c_ctrl_pass;
        if (rst) begin
            w_ctrl = c_ctrl_reset;
        end else if (w_commit) begin
            w_ctrl = c_ctrl_commit;
        end else if (r_state == ST_DRAIN) begin
            w_ctrl.pc_wr    = 1'b0;
            w_ctrl.if_flush = 1'b1;
        end else if (w_dwait) begin
            w_ctrl = c_ctrl_hold;
        end else if (bus.div_busy) begin
            w_ctrl.pc_wr    = 1'b0;
            w_ctrl.if_id_wr = 1'b0;
            w_ctrl.id_ex_wr = 1'b0;
            w_ctrl.ex_flush = 1'b1;
        end else if (bus.load_use) begin
            w_ctrl.pc_wr    = 1'b0;
            w_ctrl.if_id_wr = 1'b0;
            w_ctrl.id_flush = 1'b1;
        end else if (w_fwait) begin
            w_ctrl.pc_wr    = 1'b0;
            w_ctrl.if_flush = 1'b1;
        end
    end

    assign w_wait_cycle = ~rst & ~w_commit & (r_state != ST_DRAIN) & w_dwait;

    pipe_ctrl_perf #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_perf (
        .clk         (clk),
        .rst         (rst),
        .i_stall     (~w_ctrl.pc_wr),
        .i_wait      (w_wait_cycle),
        .o_stall_cnt (bus.stall_cnt),
        .o_wdog_to   (bus.wdog_to)
    );

    assign bus.inst_req  = w_inst_req;
    assign bus.pc_wr     = w_ctrl.pc_wr;
    assign bus.if_id_wr  = w_ctrl.if_id_wr;
    assign bus.id_ex_wr  = w_ctrl.id_ex_wr;
    assign bus.ex_mem_wr = w_ctrl.ex_mem_wr;
    assign bus.mem_wb_wr = w_ctrl.mem_wb_wr;
    assign bus.PC_Flush  = w_ctrl.pc_flush;
    assign bus.IF_Flush  = w_ctrl.if_flush;
    assign bus.ID_Flush  = w_ctrl.id_flush;
    assign bus.EX_Flush  = w_ctrl.ex_flush;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// =============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed scoreboard bench for the pipeline stall/flush controller.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam bit [7:0] EXC  = 8'h80;
    localparam bit [7:0] ERET = 8'h40;
    localparam bit [7:0] DREQ = 8'h20;
    localparam bit [7:0] DOK  = 8'h10;
    localparam bit [7:0] DIV  = 8'h08;
    localparam bit [7:0] LU   = 8'h04;
    localparam bit [7:0] AOK  = 8'h02;
    localparam bit [7:0] IOK  = 8'h01;

    // wr order {pc, if_id, id_ex, ex_mem, mem_wb}; flush order {PC, IF, ID, EX}
    localparam bit [4:0] WR_ALL  = 5'b11111;
    localparam bit [4:0] WR_NONE = 5'b00000;
    localparam bit [4:0] WR_NOPC = 5'b01111;
    localparam bit [4:0] WR_DIV  = 5'b00011;
    localparam bit [4:0] WR_LU   = 5'b00111;
    localparam bit [3:0] FL_ALL  = 4'b1111;
    localparam bit [3:0] FL_NONE = 4'b0000;
    localparam bit [3:0] FL_IF   = 4'b0100;
    localparam bit [3:0] FL_ID   = 4'b0010;
    localparam bit [3:0] FL_EX   = 4'b0001;

    typedef struct {
        string      tag;
        logic [9:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .WDOG_LIMIT (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] observed();
        return {bus.pc_wr, bus.if_id_wr, bus.id_ex_wr, bus.ex_mem_wr, bus.mem_wb_wr,
                bus.PC_Flush, bus.IF_Flush, bus.ID_Flush, bus.EX_Flush, bus.inst_req};
    endfunction

    task automatic compare_head();
        exp_t       e;
        logic [9:0] got;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL scoreboard_empty got 0 entries exp 1");
        end else begin
            e   = sb.pop_front();
            got = observed();
            n_checks++;
            assert (got === e.val) else begin
                n_errors++;
                $error("FAIL %s got wr=%b fl=%b ireq=%b exp wr=%b fl=%b ireq=%b",
                       e.tag, got[9:5], got[4:1], got[0], e.val[9:5], e.val[4:1], e.val[0]);
            end
        end
    endtask

    task automatic step(input logic [7:0] in, input string tag,
                        input logic [4:0] wr, input logic [3:0] fl, input logic ireq);
        exp_t e;
        {bus.exc_commit, bus.eret_commit, bus.data_req, bus.data_data_ok,
         bus.div_busy, bus.load_use, bus.inst_addr_ok, bus.inst_data_ok} = in;
        e.tag = tag;
        e.val = {wr, fl, ireq};
        sb.push_back(e);
        @(negedge clk);
        compare_head();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s got %0d exp %0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        {bus.exc_commit, bus.eret_commit, bus.data_req, bus.data_data_ok,
         bus.div_busy, bus.load_use, bus.inst_addr_ok, bus.inst_data_ok} = 8'h00;
        #1;

        // Reset: wr low, flushes high, no fetch
        step(8'h00, "reset_0", WR_NONE, FL_ALL, 1'b0);
        step(8'h00, "reset_1", WR_NONE, FL_ALL, 1'b0);
        chk("reset_stall_cnt", bus.stall_cnt, 16'd0);
        chk("reset_wdog", {15'd0, bus.wdog_to}, 16'd0);
        rst = 1'b0;

        // Free-running fetch, no hazards: request alternates with return
        for (int i = 0; i < 6; i++) begin
            step(AOK | IOK, "run_free", WR_ALL, FL_NONE, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        chk("run_stall_cnt", bus.stall_cnt, 16'd0);

        // Data wait of three cycles then ok
        step(DREQ | AOK | IOK, "dwait_entry", WR_NONE, FL_NONE, 1'b0);
        step(DREQ | AOK | IOK, "dwait_1", WR_NONE, FL_NONE, 1'b0);
        step(DREQ | AOK | IOK, "dwait_2", WR_NONE, FL_NONE, 1'b0);
        step(DREQ | DOK | AOK | IOK, "dwait_ok", WR_ALL, FL_NONE, 1'b0);
        chk("dwait_stall_cnt", bus.stall_cnt, 16'd3);
        step(8'h00, "dwait_back_run", WR_ALL, FL_NONE, 1'b1);

        // Exception with a fetch outstanding: drain two cycles
        step(AOK, "exc_fetch", WR_ALL, FL_NONE, 1'b1);
        step(EXC, "exc_commit", WR_ALL, FL_ALL, 1'b0);
        step(8'h00, "drain_1", WR_NOPC, FL_IF, 1'b0);
        step(IOK, "drain_2", WR_NOPC, FL_IF, 1'b0);
        step(8'h00, "drain_exit", WR_ALL, FL_NONE, 1'b1);
        chk("drain_stall_cnt", bus.stall_cnt, 16'd5);

        // Second commit while draining
        step(AOK, "eret_fetch", WR_ALL, FL_NONE, 1'b1);
        step(ERET, "eret_commit", WR_ALL, FL_ALL, 1'b0);
        step(ERET, "eret_in_drain", WR_ALL, FL_ALL, 1'b0);
        step(8'h00, "eret_drain_1", WR_NOPC, FL_IF, 1'b0);
        step(IOK, "eret_drain_2", WR_NOPC, FL_IF, 1'b0);
        chk("eret_stall_cnt", bus.stall_cnt, 16'd7);

        // div_busy outranks load_use
        for (int i = 0; i < 4; i++) begin
            step(DIV | LU, "div_and_lu", WR_DIV, FL_EX, 1'b1);
        end
        step(LU, "load_use", WR_LU, FL_ID, 1'b1);
        step(AOK, "fw_issue", WR_ALL, FL_NONE, 1'b1);
        step(8'h00, "fetch_wait", WR_NOPC, FL_IF, 1'b0);
        step(IOK, "fetch_ret", WR_ALL, FL_NONE, 1'b0);
        chk("hazard_stall_cnt", bus.stall_cnt, 16'd13);

        // Commit beats a same-cycle data wait; no DWAIT entry
        step(EXC | DREQ, "commit_vs_dwait", WR_ALL, FL_ALL, 1'b0);
        step(8'h00, "commit_no_dwait", WR_ALL, FL_NONE, 1'b1);

        // Reset mid-DWAIT
        step(DREQ, "rst_dw_entry", WR_NONE, FL_NONE, 1'b0);
        step(DREQ, "rst_dw_wait", WR_NONE, FL_NONE, 1'b0);
        rst = 1'b1;
        step(DREQ, "rst_dw_reset", WR_NONE, FL_ALL, 1'b0);
        rst = 1'b0;
        step(8'h00, "rst_dw_after", WR_ALL, FL_NONE, 1'b1);

        // Reset mid-DRAIN
        step(AOK, "rst_dr_fetch", WR_ALL, FL_NONE, 1'b1);
        step(EXC, "rst_dr_commit", WR_ALL, FL_ALL, 1'b0);
        step(8'h00, "rst_dr_drain", WR_NOPC, FL_IF, 1'b0);
        rst = 1'b1;
        step(8'h00, "rst_dr_reset", WR_NONE, FL_ALL, 1'b0);
        rst = 1'b0;
        chk("rst_dr_stall_cnt", bus.stall_cnt, 16'd0);
        step(8'h00, "rst_dr_after", WR_ALL, FL_NONE, 1'b1);

        // Watchdog: 255 consecutive waiting cycles
        for (int i = 0; i < 254; i++) begin
            step(DREQ, "wdog_wait", WR_NONE, FL_NONE, 1'b0);
        end
        chk("wdog_before_limit", {15'd0, bus.wdog_to}, 16'd0);
        step(DREQ, "wdog_wait_last", WR_NONE, FL_NONE, 1'b0);
        chk("wdog_at_limit", {15'd0, bus.wdog_to}, 16'd1);
        step(DREQ | DOK, "wdog_ok", WR_ALL, FL_NONE, 1'b0);
        chk("wdog_held_ok", {15'd0, bus.wdog_to}, 16'd1);
        step(8'h00, "wdog_idle", WR_ALL, FL_NONE, 1'b1);
        chk("wdog_held_idle", {15'd0, bus.wdog_to}, 16'd1);
        chk("wdog_stall_cnt", bus.stall_cnt, 16'd255);
        rst = 1'b1;
        step(8'h00, "wdog_reset", WR_NONE, FL_ALL, 1'b0);
        chk("wdog_cleared", {15'd0, bus.wdog_to}, 16'd0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
